// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path.
// Frame-length helper for frame timing.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } tx_state_e;

  function automatic int frame_bits(int dw, int par, int sb);
    return 1 + dw + ((par != 0) ? 1 : 0) + sb;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with ready/valid write and pop strobe.
// Pointers carry one extra wrap bit for full/empty.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     wvalid_i,
  output logic                     wready_o,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]     wptr_q;
  logic [PW-1:0]     rptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              full;
  logic              we;
  logic              re;

  assign full = (wptr_q[AW] != rptr_q[AW]) &&
                (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o  = (wptr_q == rptr_q);
  assign wready_o = !full;
  assign we       = wvalid_i && !full;
  assign re       = pop_i && !empty_o;
  assign rdata_o  = mem_q[rptr_q[AW-1:0]];
  assign count_o  = wptr_q - rptr_q;

  // Pointer update; wrap bit distinguishes full from empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (we) wptr_q <= wptr_q + PW'(1);
      if (re) rptr_q <= rptr_q + PW'(1);
    end
  end

  // Storage array, written on accepted handshake.
  always_ff @(posedge clk_i) begin
    if (we) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO, parity, stop bits,
// runtime prescale and break generation.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int PRESCALE_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [PRESCALE_W-1:0]    prescale_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic                     break_i,
  output logic                     tx_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int BW = $clog2(DATA_W + 2);
  localparam parity_e PMODE = parity_e'(2'(PARITY));
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] BRK_LAST  = BW'(DATA_W + 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  tx_state_e         state_q;
  logic              tx_q;
  logic [PRESCALE_W-1:0] timer_q;
  logic [PRESCALE_W-1:0] pres_q;
  logic [BW-1:0]     bit_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_q;
  logic              brk_pend_q;

  logic [DATA_W-1:0] f_data;
  logic              f_empty;
  logic              pop;
  logic              bit_end;
  logic              brk_req;
  logic              stop_done;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wdata_i  (data_i),
    .wvalid_i (valid_i),
    .wready_o (ready_o),
    .pop_i    (pop),
    .rdata_o  (f_data),
    .empty_o  (f_empty),
    .count_o  (count_o)
  );

  assign bit_end   = (timer_q == '0);
  assign brk_req   = break_i || brk_pend_q;
  assign stop_done = (state_q == ST_STOP) && bit_end &&
                     (bit_q == '0);
  assign pop       = !f_empty && !brk_req &&
                     ((state_q == ST_IDLE) || stop_done);
  assign busy_o    = (state_q != ST_IDLE);
  assign tx_o      = tx_q;

  // Frame sequencer: bit timer, shifter and registered line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      tx_q       <= 1'b1;
      timer_q    <= '0;
      pres_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      brk_pend_q <= 1'b0;
    end else begin
      if (break_i && state_q != ST_IDLE &&
          state_q != ST_BREAK)
        brk_pend_q <= 1'b1;
      if (!bit_end) timer_q <= timer_q - PRESCALE_W'(1);
      unique case (state_q)
        ST_IDLE: begin
          if (brk_req) begin
            state_q    <= ST_BREAK;
            tx_q       <= 1'b0;
            pres_q     <= prescale_i;
            timer_q    <= prescale_i;
            bit_q      <= '0;
            brk_pend_q <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state_q <= ST_DATA;
            tx_q    <= shift_q[0];
            timer_q <= pres_q;
            bit_q   <= '0;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            timer_q <= pres_q;
            if (bit_q == DATA_LAST) begin
              if (PMODE != PARITY_NONE) begin
                state_q <= ST_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= ST_STOP;
                tx_q    <= 1'b1;
                bit_q   <= STOP_LAST;
              end
            end else begin
              bit_q   <= bit_q + BW'(1);
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state_q <= ST_STOP;
            tx_q    <= 1'b1;
            timer_q <= pres_q;
            bit_q   <= STOP_LAST;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (bit_q != '0) begin
              bit_q   <= bit_q - BW'(1);
              timer_q <= pres_q;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_BREAK: begin
          if (bit_end) begin
            timer_q <= pres_q;
            if (bit_q == BRK_LAST) begin
              if (!break_i) begin
                state_q <= ST_STOP;
                tx_q    <= 1'b1;
                bit_q   <= '0;
              end
            end else begin
              bit_q <= bit_q + BW'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (pop) begin
        state_q <= ST_START;
        tx_q    <= 1'b0;
        pres_q  <= prescale_i;
        timer_q <= prescale_i;
        shift_q <= f_data;
        par_q   <= (^f_data) ^ (PMODE == PARITY_ODD);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: waveform, parity,
// FIFO fill/wrap, break and async reset.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pres = 16'd3;

  logic [7:0] d0 = '0, d1 = '0, d2 = '0;
  logic       v0 = 0, v1 = 0, v2 = 0, b0 = 0;
  logic       r0, r1, r2, tx0, tx1, tx2;
  logic       busy0, busy1, busy2;
  logic [4:0] cnt0, cnt1, cnt2;

  int n_chk = 0;
  int n_fail = 0;

  logic       cap [0:2047];
  logic [7:0] rxq [$];
  bit         mon_en = 0;

  always #5 clk = ~clk;

  uart_tx_fifo u_dut (
    .clk_i(clk), .rst_i(rst), .prescale_i(pres),
    .data_i(d0), .valid_i(v0), .ready_o(r0),
    .break_i(b0), .tx_o(tx0), .busy_o(busy0),
    .count_o(cnt0)
  );

  uart_tx_fifo #(.PARITY(1), .STOP_BITS(2)) u_even (
    .clk_i(clk), .rst_i(rst), .prescale_i(pres),
    .data_i(d1), .valid_i(v1), .ready_o(r1),
    .break_i(1'b0), .tx_o(tx1), .busy_o(busy1),
    .count_o(cnt1)
  );

  uart_tx_fifo #(.PARITY(2), .STOP_BITS(2)) u_odd (
    .clk_i(clk), .rst_i(rst), .prescale_i(pres),
    .data_i(d2), .valid_i(v2), .ready_o(r2),
    .break_i(1'b0), .tx_o(tx2), .busy_o(busy2),
    .count_o(cnt2)
  );

  task automatic check_eq(string tag, logic [31:0] got,
                          logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic tx_of(int sel);
    return (sel == 0) ? tx0 : (sel == 1) ? tx1 : tx2;
  endfunction

  function automatic logic busy_of(int sel);
    return (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
  endfunction

  // entered and left at a negedge
  task automatic push0(input logic [7:0] d);
    int t;
    t = 0;
    d0 = d;
    v0 = 1'b1;
    while (!r0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check_eq("push_rdy", 32'(r0), 32'd1);
    @(negedge clk);
    v0 = 1'b0;
  endtask

  task automatic capture(input int sel, output int n);
    int t;
    t = 0;
    n = 0;
    while (!busy_of(sel) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    while (busy_of(sel) && n < 2048) begin
      cap[n] = tx_of(sel);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic q_check(string tag, logic [7:0] exp);
    logic [31:0] g;
    g = 32'hFFFF_FFFF;
    if (rxq.size() > 0) g = 32'(rxq.pop_front());
    check_eq(tag, g, 32'(exp));
  endtask

  // 8N1 line receiver on the main instance
  initial begin : mon
    int p;
    logic [7:0] b;
    logic sb;
    forever begin
      @(negedge clk);
      if (mon_en && tx0 === 1'b0 && !rst) begin
        p = int'(pres) + 1;
        b = '0;
        sb = 1'b0;
        for (int k = 1; k < 10 * p; k++) begin
          @(negedge clk);
          for (int j = 0; j < 8; j++)
            if (k == p * (j + 1) + p / 2) b[j] = tx0;
          if (k == 9 * p + p / 2) sb = tx0;
        end
        if (sb) rxq.push_back(b);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, n1, n2, t, z;
    logic [9:0]  ef;
    logic [11:0] fv;
    logic [3:0]  seg;

    repeat (3) @(negedge clk);
    check_eq("rst_tx", 32'(tx0), 32'd1);
    check_eq("rst_busy", 32'(busy0), 32'd0);
    check_eq("rst_rdy", 32'(r0), 32'd1);
    check_eq("rst_cnt", 32'(cnt0), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // single 8N1 byte, 4 cycles per bit
    pres = 16'd3;
    mon_en = 1;
    fork
      push0(8'hA5);
      capture(0, n);
    join
    check_eq("a5_busy_len", 32'(n),
             32'(frame_bits(8, 0, 1) * 4));
    ef = 10'b1101001010;
    for (int i = 0; i < 10; i++) begin
      seg = {cap[4*i], cap[4*i+1], cap[4*i+2], cap[4*i+3]};
      check_eq($sformatf("a5_bit%0d", i), 32'(seg),
               32'({4{ef[i]}}));
    end
    q_check("a5_rx", 8'hA5);

    // even parity, two stops, prescale 0
    pres = 16'd0;
    d1 = 8'h07;
    v1 = 1'b1;
    fork
      begin
        @(negedge clk);
        v1 = 1'b0;
      end
      capture(1, n);
    join
    check_eq("even_len", 32'(n), 32'd12);
    for (int i = 0; i < 12; i++) fv[i] = cap[i];
    check_eq("even_frame", 32'(fv), 32'b111000001110);
    check_eq("even_par", 32'(cap[9]), 32'd1);

    // odd parity, same data
    d2 = 8'h07;
    v2 = 1'b1;
    fork
      begin
        @(negedge clk);
        v2 = 1'b0;
      end
      capture(2, n);
    join
    check_eq("odd_len", 32'(n), 32'd12);
    for (int i = 0; i < 12; i++) fv[i] = cap[i];
    check_eq("odd_frame", 32'(fv), 32'b110000001110);
    check_eq("odd_par", 32'(cap[9]), 32'd0);

    // fill FIFO behind a long frame
    pres = 16'd7;
    rxq.delete();
    @(negedge clk);
    fork
      begin
        for (int k = 0; k < 17; k++) push0(8'(k * 37 + 11));
        check_eq("full_cnt", 32'(cnt0), 32'd16);
        check_eq("full_rdy", 32'(r0), 32'd0);
        push0(8'(17 * 37 + 11));
        check_eq("refill_cnt", 32'(cnt0), 32'd16);
      end
      capture(0, n);
    join
    check_eq("fill_run_len", 32'(n), 32'd1440);
    check_eq("fill_rx_n", 32'(rxq.size()), 32'd18);
    for (int k = 0; k < 18; k++)
      q_check($sformatf("fill_rx%0d", k), 8'(k * 37 + 11));

    // push and pop together at count 5, pointer wrap
    pres = 16'd0;
    mon_en = 0;
    rxq.delete();
    b0 = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) push0(8'(8'h80 + k));
    check_eq("pre_cnt", 32'(cnt0), 32'd5);
    repeat (12) @(negedge clk);
    b0 = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (tx0 !== 1'b1 && t < 40);
    check_eq("brk_stop", 32'(tx0), 32'd1);
    mon_en = 1;
    d0 = 8'h55;
    v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    check_eq("pushpop_cnt", 32'(cnt0), 32'd5);
    check_eq("pushpop_start", 32'(tx0), 32'd0);
    for (int k = 0; k < 10; k++) push0(8'(8'hC0 + k));
    t = 0;
    while (rxq.size() < 16 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check_eq("wrap_rx_n", 32'(rxq.size()), 32'd16);
    for (int k = 0; k < 5; k++)
      q_check($sformatf("wrap_a%0d", k), 8'(8'h80 + k));
    q_check("wrap_x", 8'h55);
    for (int k = 0; k < 10; k++)
      q_check($sformatf("wrap_b%0d", k), 8'(8'hC0 + k));

    // one-cycle break at prescale 0
    repeat (5) @(negedge clk);
    mon_en = 0;
    fork
      begin
        b0 = 1'b1;
        @(negedge clk);
        b0 = 1'b0;
      end
      capture(0, n);
    join
    check_eq("brk_len", 32'(n), 32'd11);
    fv = '0;
    for (int i = 0; i < 11; i++) fv[i] = cap[i];
    check_eq("brk_wave", 32'(fv), 32'b10000000000);
    check_eq("brk_idle", 32'(busy0), 32'd0);

    // break requested mid-frame waits for the stop bit
    pres = 16'd3;
    fork
      begin
        push0(8'h3C);
        repeat (14) @(negedge clk);
        b0 = 1'b1;
        @(negedge clk);
        b0 = 1'b0;
      end
      begin
        capture(0, n1);
        for (int i = 0; i < 10; i++) ef[i] = cap[4*i];
        capture(0, n2);
      end
    join
    check_eq("mid_frame_len", 32'(n1), 32'd40);
    check_eq("mid_frame_wave", 32'(ef), 32'b1001111000);
    check_eq("mid_brk_len", 32'(n2), 32'd44);
    z = 0;
    for (int i = 0; i < 40; i++) if (cap[i] === 1'b0) z++;
    check_eq("mid_brk_low", 32'(z), 32'd40);
    seg = {cap[40], cap[41], cap[42], cap[43]};
    check_eq("mid_brk_stop", 32'(seg), 32'hF);

    // async reset during data bit 3
    @(negedge clk);
    fork
      begin
        push0(8'hF0);
        push0(8'h11);
        push0(8'h22);
      end
      begin
        t = 0;
        while (!busy0 && t < 100) begin
          @(negedge clk);
          t++;
        end
        repeat (17) @(negedge clk);
      end
    join
    check_eq("pre_rst_tx", 32'(tx0), 32'd0);
    check_eq("pre_rst_cnt", 32'(cnt0), 32'd2);
    rst = 1'b1;
    #1;
    check_eq("arst_tx", 32'(tx0), 32'd1);
    check_eq("arst_busy", 32'(busy0), 32'd0);
    check_eq("arst_cnt", 32'(cnt0), 32'd0);
    check_eq("arst_rdy", 32'(r0), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rxq.delete();
    mon_en = 1;
    fork
      push0(8'h5A);
      capture(0, n);
    join
    check_eq("post_rst_len", 32'(n), 32'd40);
    q_check("post_rst_rx", 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
